vga_sync_receptor: RTL and testbench
====================================

Name: vga_sync_receptor

Overview:
- Receiving end of the 640x480 VGA timing interface: consumes active-low hsync/vsync plus the pixel tick, and re-derives pixel_X/pixel_Y coordinates and video_on.
- Measures line and frame periods and asserts locked only while the incoming timing matches the standard.
- Used for loopback self-check of the display path and by downstream blocks that only see the sync wires.

Parameters:
- HM, 640, visible pixels per line
- H_FP, 16, horizontal front porch (hsync asserts at pixel HM+H_FP)
- H_TOTAL, 800, pixels per line
- VM, 480, visible lines
- V_FP, 10, vertical front porch (vsync asserts at line VM+V_FP)
- V_TOTAL, 525, lines per frame
- LOCK_LINES, 4, consecutive correct lines needed before frame alignment

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- p_tick  in  1  pixel enable; one pixel per rising edge of p_tick
- sincro_horiz  in  1  hsync, active low
- sincro_vert  in  1  vsync, active low
- pixel_X  out  10  recovered column 0..799
- pixel_Y  out  10  recovered row 0..524
- video_on  out  1  locked && pixel_X<HM && pixel_Y<VM
- locked  out  1  timing verified
- sync_err  out  1  one-CLK pulse on loss of lock
- frame_start  out  1  one-CLK pulse on each vsync assertion edge
- h_period  out  11  last measured line length (MEAS_OUT_EN)
- v_period  out  11  last measured frame length in lines (MEAS_OUT_EN)

Behaviour:
- Reset is synchronous and active-high, on CLK. Reset values: pixel_X=0, pixel_Y=0, video_on=0, locked=0, sync_err=0, frame_start=0, state=ST_SEARCH, all counters 0, previous-sample regs for p_tick/hsync/vsync = 0/1/1 (no false edge after reset).
- Pixel event (pe): p_tick=1 and previous-CLK p_tick=0. Works for 1-CLK strobes and 50% duty ticks. A constantly high p_tick gives no pe.
- hsync/vsync are sampled only on pe. An assertion edge is: previous sample 1, current sample 0.
- X counter, every pe:
  - hsync edge: pixel_X <= HM+H_FP (656).
  - otherwise: pixel_X increments, and wraps 799 -> 0.
- Y counter:
  - Increments when pixel_X wraps 799 -> 0 (524 -> 0).
  - vsync edge: pixel_Y <= VM+V_FP (490). This takes priority over an increment in the same pe.
  - Alignment loads happen in every state.
- Line measurement:
  - 11-bit h_meas counts pe since the last hsync edge and saturates at 2047.
  - On an hsync edge, h_meas is compared to H_TOTAL, then reloaded to 1.
  - Frame measurement: v_meas counts hsync edges since the last vsync edge; compared to V_TOTAL on each vsync edge.
- FSM, states ST_SEARCH, ST_HLOCK, ST_VALIGN, ST_LOCKED:
  - ST_SEARCH: count consecutive good lines (h_meas==H_TOTAL at an hsync edge); a bad line clears the count. After LOCK_LINES good lines -> ST_HLOCK.
  - ST_HLOCK: a bad line -> ST_SEARCH. The first vsync edge -> ST_VALIGN (v_meas cleared).
  - ST_VALIGN: a bad line -> ST_SEARCH. On a vsync edge, v_meas==V_TOTAL -> ST_LOCKED; otherwise stay (v_meas cleared).
  - ST_LOCKED: any of the following -> ST_SEARCH and a one-CLK sync_err pulse:
    - bad line,
    - v_meas!=V_TOTAL at a vsync edge,
    - h_meas exceeding 2*H_TOTAL (1600) with no hsync edge (timeout).
  - If a bad line and a vsync error occur on the same pe, only one sync_err pulse is issued.
- locked = (state==ST_LOCKED), registered. It rises on the CLK following the qualifying vsync edge and falls together with the sync_err pulse.
- frame_start pulses on vsync edges in every state.
- Output latency: registered outputs, one CLK after the pe that updates them.

Optional Feature:
- Macro MEAS_OUT_EN.
- Defined: h_period/v_period update on each hsync/vsync edge with the measured value (h_meas saturated at 2047, v_meas saturated at 2047). Both reset to 0.
- Undefined: both ports tied to 0 and the measurement-hold registers removed. The lock FSM is unaffected.

Test Plan:
- Reset, then drive ideal 800x525 timing with a 50% p_tick (2 CLK high / 2 low) -> locked=1 after the 2nd vsync edge following 4 good lines; pixel_X=656 on the hsync-edge pe; pixel_Y=490 on the vsync edge; video_on=1 exactly at X 0..639, Y 0..479.
- While locked, one line of 801 pixels -> single 1-CLK sync_err, locked=0, state ST_SEARCH; relocks after 4 good lines plus one full 525-line frame.
- While locked, hold hsync high -> locked falls on the 1601st pe without an edge, with one sync_err pulse.
- Frames of 524 lines with correct lines -> FSM stays in ST_VALIGN, locked remains 0, frame_start pulses every frame.
- Assert RESET for one CLK mid-frame while locked -> next CLK all outputs 0; p_tick held constantly high -> pixel_X frozen.
- MEAS_OUT_EN defined, ideal timing -> h_period=800, v_period=525 after the first full frame. Undefined -> both read 0.

Source files
------------

// File: rtl/vga_sync_receptor.sv
// vga_sync_receptor: recovers pixel_X/pixel_Y/video_on and a lock flag from active-low hsync/vsync plus p_tick; outputs registered 1 CLK after each pixel event, no backpressure.
// Optional MEAS_OUT_EN: exposes the last measured line/frame lengths on h_period/v_period (tied to 0 otherwise).
module vga_sync_receptor #(
  parameter int HM         = 640,
  parameter int H_FP       = 16,
  parameter int H_TOTAL    = 800,
  parameter int VM         = 480,
  parameter int V_FP       = 10,
  parameter int V_TOTAL    = 525,
  parameter int LOCK_LINES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        p_tick,
  input  logic        sincro_horiz,
  input  logic        sincro_vert,
  output logic [9:0]  pixel_X,
  output logic [9:0]  pixel_Y,
  output logic        video_on,
  output logic        locked,
  output logic        sync_err,
  output logic        frame_start,
  output logic [10:0] h_period,
  output logic [10:0] v_period
);

  localparam logic [9:0]  X_HS      = 10'(HM + H_FP);
  localparam logic [9:0]  X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_VS      = 10'(VM + V_FP);
  localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  X_VIS     = 10'(HM);
  localparam logic [9:0]  Y_VIS     = 10'(VM);
  localparam logic [10:0] H_LEN     = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN     = 11'(V_TOTAL);
  localparam logic [10:0] H_TMO     = 11'(2 * H_TOTAL);
  localparam logic [10:0] MEAS_MAX  = 11'h7FF;
  localparam logic [3:0]  GOOD_LAST = 4'(LOCK_LINES - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_HLOCK, ST_VALIGN, ST_LOCKED} state_t;

  state_t      state;
  logic        tick_q, hs_q, vs_q;
  logic [10:0] h_meas, v_meas;
  logic [3:0]  good_cnt;
  logic        pe, h_edge, v_edge, line_ok, frame_ok, h_tmo;

  assign pe       = p_tick & ~tick_q;
  assign h_edge   = pe & hs_q & ~sincro_horiz;
  assign v_edge   = pe & vs_q & ~sincro_vert;
  assign line_ok  = (h_meas == H_LEN);
  assign frame_ok = (v_meas == V_LEN);
  assign h_tmo    = pe & ~h_edge & (h_meas > H_TMO);
  assign video_on = locked && (pixel_X < X_VIS) && (pixel_Y < Y_VIS);

  // Sync samples reset to the idle level so the first sample cannot fake an edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_q      <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      pixel_X     <= '0;
      pixel_Y     <= '0;
      h_meas      <= '0;
      v_meas      <= '0;
      frame_start <= 1'b0;
    end else begin
      tick_q      <= p_tick;
      frame_start <= v_edge;
      if (pe) begin
        hs_q <= sincro_horiz;
        vs_q <= sincro_vert;
        if (h_edge)
          pixel_X <= X_HS;
        else if (pixel_X == X_LAST)
          pixel_X <= '0;
        else
          pixel_X <= pixel_X + 10'd1;
        if (v_edge)
          pixel_Y <= Y_VS;
        else if (!h_edge && pixel_X == X_LAST)
          pixel_Y <= (pixel_Y == Y_LAST) ? 10'd0 : pixel_Y + 10'd1;
        if (h_edge)
          h_meas <= 11'd1;
        else if (h_meas != MEAS_MAX)
          h_meas <= h_meas + 11'd1;
        if (v_edge)
          v_meas <= {10'd0, h_edge};
        else if (h_edge && v_meas != MEAS_MAX)
          v_meas <= v_meas + 11'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (h_edge) begin
            if (!line_ok) begin
              good_cnt <= '0;
            end else if (good_cnt == GOOD_LAST) begin
              good_cnt <= '0;
              state    <= ST_HLOCK;
            end else begin
              good_cnt <= good_cnt + 4'd1;
            end
          end
        end
        ST_HLOCK: begin
          if (h_edge && !line_ok)
            state <= ST_SEARCH;
          else if (v_edge)
            state <= ST_VALIGN;
        end
        ST_VALIGN: begin
          if (h_edge && !line_ok) begin
            state <= ST_SEARCH;
          end else if (v_edge && frame_ok) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
          end
        end
        ST_LOCKED: begin
          // All loss causes merge into a single error pulse.
          if ((h_edge && !line_ok) || (v_edge && !frame_ok) || h_tmo) begin
            state    <= ST_SEARCH;
            locked   <= 1'b0;
            sync_err <= 1'b1;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEAS_OUT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_period <= '0;
      v_period <= '0;
    end else begin
      if (h_edge) h_period <= h_meas;
      if (v_edge) v_period <= v_meas;
    end
  end
`else
  assign h_period = '0;
  assign v_period = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receptor.sv
// tb_vga_sync_receptor: drives a scaled-down VGA raster with random p_tick duty and checks every pixel
// against a lock/alignment reference built from line/frame lengths measured on the transmitted stream.
module tb_vga_sync_receptor;
  localparam int HM = 16, H_FP = 4, H_TOTAL = 24, VM = 8, V_FP = 2, V_TOTAL = 12, LOCK_LINES = 4;
  localparam int HSW = 3;
  localparam int HE  = HM + H_FP;
  localparam int VE  = VM + V_FP;

  logic        CLK = 1'b0;
  logic        RESET, p_tick, sincro_horiz, sincro_vert;
  logic [9:0]  pixel_X, pixel_Y;
  logic        video_on, locked, sync_err, frame_start;
  logic [10:0] h_period, v_period;

  vga_sync_receptor #(
    .HM(HM), .H_FP(H_FP), .H_TOTAL(H_TOTAL), .VM(VM), .V_FP(V_FP),
    .V_TOTAL(V_TOTAL), .LOCK_LINES(LOCK_LINES)
  ) dut (
    .CLK(CLK), .RESET(RESET), .p_tick(p_tick), .sincro_horiz(sincro_horiz),
    .sincro_vert(sincro_vert), .pixel_X(pixel_X), .pixel_Y(pixel_Y),
    .video_on(video_on), .locked(locked), .sync_err(sync_err),
    .frame_start(frame_start), .h_period(h_period), .v_period(v_period)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_fail = 0;
  int err_seen = 0, fs_seen = 0, exp_err_total = 0, exp_fs_total = 0;

  // Reference state: transmitted coordinates plus lock bookkeeping in terms of measured lengths.
  int gx, gy, run, vs_cnt, since_h, hcnt;
  bit exp_locked, prev_hs, prev_vs, x_al, y_al, fixed_duty;

  always @(negedge CLK) begin
    if (sync_err === 1'b1) err_seen++;
    if (frame_start === 1'b1) fs_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run = 0; vs_cnt = 0; since_h = 0; hcnt = 0; exp_locked = 0;
    prev_hs = 1; prev_vs = 1; x_al = 0; y_al = 0;
  endtask

  task automatic drop();
    run = 0; vs_cnt = 0; exp_locked = 0;
  endtask

  task automatic send_pixel(input bit hs, input bit vs, input bit skip_xy);
    bit hedge, vedge, err_now;
    int len, hi_len, lo_len;
    hedge = prev_hs && !hs;
    vedge = prev_vs && !vs;
    prev_hs = hs; prev_vs = vs; err_now = 0;
    if (hedge) begin
      len = since_h; since_h = 1; hcnt++;
      if (len != H_TOTAL) begin err_now = exp_locked; drop(); end
      else run++;
    end else begin
      if (exp_locked && since_h > 2 * H_TOTAL) begin err_now = 1; drop(); end
      since_h++;
    end
    if (vedge) begin
      if (exp_locked && hcnt != V_TOTAL) begin
        err_now = 1; drop();
      end else if (run >= LOCK_LINES) begin
        vs_cnt++;
        if (vs_cnt >= 2 && hcnt == V_TOTAL) exp_locked = 1;
      end
      hcnt = 0;
    end
    if (hedge) x_al = 1;
    if (vedge) y_al = 1;
    if (err_now) exp_err_total++;
    if (vedge) exp_fs_total++;

    p_tick = 1'b1; sincro_horiz = hs; sincro_vert = vs;
    @(posedge CLK); #1;
    chk("locked", locked, exp_locked);
    chk("sync_err", sync_err, err_now);
    chk("frame_start", frame_start, vedge);
    if (!skip_xy && x_al) chk("pixel_X", pixel_X, gx);
    if (!skip_xy && y_al) chk("pixel_Y", pixel_Y, gy);
    if (!skip_xy && x_al && y_al) chk("video_on", video_on, exp_locked && gx < HM && gy < VM);
    else if (!exp_locked) chk("video_on_unlocked", video_on, 0);

    hi_len = fixed_duty ? 2 : $urandom_range(1, 3);
    lo_len = fixed_duty ? 2 : $urandom_range(1, 3);
    repeat (hi_len - 1) begin @(posedge CLK); #1; end
    p_tick = 1'b0;
    repeat (lo_len) begin @(posedge CLK); #1; end
  endtask

  task automatic send_frame(input int nlines, input int long_ln, input int nohs_lo,
                            input int nohs_hi, input int stop_line);
    bit hs, vs;
    int len;
    for (int y = 0; y < nlines; y++) begin
      if (y == stop_line) return;
      gy = y;
      len = (y == long_ln) ? H_TOTAL + 1 : H_TOTAL;
      for (int x = 0; x < len; x++) begin
        gx = x;
        hs = !(x >= HE && x < HE + HSW) || (y >= nohs_lo && y <= nohs_hi);
        vs = !(y >= VE && y < VE + 2);
        if (x == H_TOTAL) begin
          x_al = 0;
          send_pixel(hs, vs, 1);
        end else begin
          send_pixel(hs, vs, 0);
        end
      end
    end
    if (nlines != V_TOTAL) y_al = 0;
  endtask

  initial begin
    int err0, idx;
    RESET = 1'b1; p_tick = 1'b0; sincro_horiz = 1'b1; sincro_vert = 1'b1;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst pixel_X", pixel_X, 0);
    chk("rst pixel_Y", pixel_Y, 0);
    chk("rst video_on", video_on, 0);
    chk("rst locked", locked, 0);
    chk("rst sync_err", sync_err, 0);
    chk("rst frame_start", frame_start, 0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Ideal timing, 2-high/2-low tick: lock on the second vsync after four good lines.
    fixed_duty = 1;
    repeat (3) send_frame(V_TOTAL, -1, -1, -1, -1);
    fixed_duty = 0;
    chk("locked after ideal frames", locked, 1);
`ifdef MEAS_OUT_EN
    chk("h_period", h_period, H_TOTAL);
    chk("v_period", v_period, V_TOTAL);
`else
    chk("h_period", h_period, 0);
    chk("v_period", v_period, 0);
`endif

    // One over-long line while locked.
    err0 = err_seen;
    idx = $urandom_range(1, 5);
    send_frame(V_TOTAL, idx, -1, -1, -1);
    chk("long line err pulses", err_seen - err0, 1);
    repeat (3) send_frame(V_TOTAL, -1, -1, -1, -1);
    chk("relock after long line", locked, 1);

    // hsync held high for three lines: timeout.
    err0 = err_seen;
    idx = $urandom_range(1, 3);
    send_frame(V_TOTAL, -1, idx, idx + 2, -1);
    chk("timeout err pulses", err_seen - err0, 1);
    repeat (3) send_frame(V_TOTAL, -1, -1, -1, -1);
    chk("relock after timeout", locked, 1);

    // Short frames: lock lost once, then stuck in vertical alignment.
    err0 = err_seen;
    repeat (5) send_frame(V_TOTAL - 1, -1, -1, -1, -1);
    chk("short frame err pulses", err_seen - err0, 1);
    chk("unlocked on short frames", locked, 0);
    repeat (2) send_frame(V_TOTAL, -1, -1, -1, -1);
    chk("relock after short frames", locked, 1);

    chk("sync_err pulse total", err_seen, exp_err_total);
    chk("frame_start pulse total", fs_seen, exp_fs_total);

    // Mid-frame reset with p_tick already high.
    send_frame(V_TOTAL, -1, -1, -1, 3);
    chk("locked before reset", locked, 1);
    RESET = 1'b1; p_tick = 1'b1; sincro_horiz = 1'b1; sincro_vert = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("mid rst pixel_X", pixel_X, 0);
    chk("mid rst pixel_Y", pixel_Y, 0);
    chk("mid rst video_on", video_on, 0);
    chk("mid rst locked", locked, 0);
    chk("mid rst sync_err", sync_err, 0);
    chk("mid rst frame_start", frame_start, 0);
    chk("mid rst h_period", h_period, 0);
    chk("mid rst v_period", v_period, 0);
    // The idle-low tick sample after reset turns the already-high tick into exactly one pixel.
    @(posedge CLK); #1;
    chk("tick high first pixel_X", pixel_X, 1);
    repeat (20) @(posedge CLK);
    #1;
    chk("tick high frozen pixel_X", pixel_X, 1);
    chk("tick high pixel_Y", pixel_Y, 0);
    chk("tick high locked", locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
